// File: rtl/iru_coord_rotator.sv
// iru_coord_rotator: walks a WIN x WIN destination window in raster order and
// rotates each centred pixel coordinate by a latched sine/cosine pair,
// streaming (dst, src) coordinate beats out through a valid/ready handshake.
// Pipeline: counter issue -> products -> sums -> output conversion.
module iru_coord_rotator #(
    parameter int WIN = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] sin_val,
    input  logic [31:0] cos_val,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  dst_x,
    output logic [4:0]  dst_y,
    output logic [6:0]  src_x,
    output logic [6:0]  src_y,
    output logic        src_oob,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [4:0]  LAST      = 5'(WIN - 1);
    // Adding WIN in Q.30 before the shift by 31 yields floor((r + WIN) / 2).
    localparam logic [39:0] ROUND_OFS = 40'(WIN) << 30;

    state_t             state;
    logic [4:0]         cnt_x, cnt_y;
    logic signed [31:0] sin_q, cos_q;

    logic               v1, v2;
    logic [4:0]         x1, y1, x2, y2;
    logic signed [37:0] p_cx, p_sy, p_sx, p_cy;
    logic signed [38:0] rx, ry;

    logic               advance;
    logic               last_accept;
    logic signed [5:0]  dx2, dy2;

    // The whole pipeline moves together; it only stalls on a refused output beat.
    assign advance     = !(out_valid && !out_ready);
    assign last_accept = out_valid && out_ready && (dst_x == LAST) && (dst_y == LAST);
    assign busy        = (state != IDLE);

    // Negative src values look huge as unsigned, so one compare per axis covers both ends.
    assign src_oob = (src_x > 7'(WIN - 1)) || (src_y > 7'(WIN - 1));

    // Centred doubled offsets of the coordinate being issued this cycle.
    always_comb begin
        dx2 = 6'(({2'b00, cnt_x} << 1) - 7'(WIN - 1));
        dy2 = 6'(({2'b00, cnt_y} << 1) - 7'(WIN - 1));
    end

    // Control FSM: latches coefficients on start, walks the raster, pulses done.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt_x <= '0;
            cnt_y <= '0;
            sin_q <= '0;
            cos_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start landing in the done cycle belongs to the finished window.
                    if (start && !done) begin
                        sin_q <= sin_val;
                        cos_q <= cos_val;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (cnt_x == LAST) begin
                            cnt_x <= '0;
                            if (cnt_y == LAST) begin
                                cnt_y <= '0;
                                state <= DRAIN;
                            end else begin
                                cnt_y <= cnt_y + 5'd1;
                            end
                        end else begin
                            cnt_x <= cnt_x + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage valids and output registers; bubbles propagate as valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            dst_x     <= '0;
            dst_y     <= '0;
            src_x     <= '0;
            src_y     <= '0;
        end else if (advance) begin
            v1        <= (state == RUN);
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                dst_x <= x2;
                dst_y <= y2;
                src_x <= 7'(({rx[38], rx} + ROUND_OFS) >> 31);
                src_y <= 7'(({ry[38], ry} + ROUND_OFS) >> 31);
            end
        end
    end

    // Datapath stages: products, then rotated sums, carried with their dst tags.
    // NOTE: these registers have no reset; the stage valids above qualify them,
    // so whatever they hold after reset is never presented as a beat.
    always_ff @(posedge clk) begin
        if (advance) begin
            x1   <= cnt_x;
            y1   <= cnt_y;
            p_cx <= 38'(cos_q) * 38'(dx2);
            p_sy <= 38'(sin_q) * 38'(dy2);
            p_sx <= 38'(sin_q) * 38'(dx2);
            p_cy <= 38'(cos_q) * 38'(dy2);
            x2   <= x1;
            y2   <= y1;
            rx   <= {p_cx[37], p_cx} + {p_sy[37], p_sy};
            ry   <= {p_cy[37], p_cy} - {p_sx[37], p_sx};
        end
    end

endmodule

// File: tb/tb_iru_coord_rotator.sv
// Self-checking bench for iru_coord_rotator: expected beats come from an
// integer reference of the rotation formula and are queued at start; a
// monitor pops and compares every accepted beat and watches stalls and done.
module tb_iru_coord_rotator;

    localparam int WIN = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] sin_val = '0;
    logic [31:0] cos_val = '0;
    logic        busy, out_valid, src_oob, done;
    logic [4:0]  dst_x, dst_y;
    logic [6:0]  src_x, src_y;

    iru_coord_rotator #(.WIN(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sin_val   (sin_val),
        .cos_val   (cos_val),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .src_x     (src_x),
        .src_y     (src_y),
        .src_oob   (src_oob),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] dx;
        logic [4:0] dy;
        logic [6:0] sx;
        logic [6:0] sy;
        logic       oob;
    } beat_t;

    beat_t sb_q[$];
    int    total = 0;
    int    bad = 0;
    int    acc_total = 0;
    int    done_cnt = 0;
    bit    rnd_ready = 1'b0;
    bit    exp_done = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t e;
    logic [6:0] got_sx [WIN][WIN];
    logic [6:0] got_sy [WIN][WIN];
    logic       got_oob[WIN][WIN];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: rotate the centred doubled offset, then floor((r + WIN) / 2).
    function automatic beat_t model(input int x, input int y,
                                    input logic [31:0] s, input logic [31:0] c);
        beat_t  m;
        longint sl, cl, dx2, dy2, rx, ry, fx, fy;
        logic signed [6:0] tx, ty;
        sl  = longint'($signed(s));
        cl  = longint'($signed(c));
        dx2 = 2 * x - (WIN - 1);
        dy2 = 2 * y - (WIN - 1);
        rx  = cl * dx2 + sl * dy2;
        ry  = cl * dy2 - sl * dx2;
        fx  = (rx + (longint'(WIN) <<< 30)) >>> 31;
        fy  = (ry + (longint'(WIN) <<< 30)) >>> 31;
        tx  = 7'(fx);
        ty  = 7'(fy);
        m.dx  = 5'(x);
        m.dy  = 5'(y);
        m.sx  = tx;
        m.sy  = ty;
        m.oob = (tx < 0) || (tx >= WIN) || (ty < 0) || (ty >= WIN);
        return m;
    endfunction

    // Consumer: ready always high, or high 30% of cycles.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Monitor: sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        cur = {dst_x, dst_y, src_x, src_y, src_oob};
        if (!rst_n) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done || exp_done) check("done_pulse", done, exp_done);
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_beat_held", cur, held);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_dst_x", dst_x, e.dx);
                    check("beat_dst_y", dst_y, e.dy);
                    check("beat_src_x", $signed(src_x), $signed(e.sx));
                    check("beat_src_y", $signed(src_y), $signed(e.sy));
                    check("beat_src_oob", src_oob, e.oob);
                    if (e.dx == 5'(WIN - 1) && e.dy == 5'(WIN - 1)) exp_done = 1'b1;
                end
                if (dst_x < WIN && dst_y < WIN) begin
                    got_sx[dst_x][dst_y]  = src_x;
                    got_sy[dst_x][dst_y]  = src_y;
                    got_oob[dst_x][dst_y] = src_oob;
                end
                acc_total++;
            end
            prev_stall = out_valid && !out_ready;
            held = cur;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_src_oob"}, src_oob, 0);
        check({tag, "_dst_x"}, dst_x, 0);
        check({tag, "_dst_y"}, dst_y, 0);
        check({tag, "_src_x"}, src_x, 0);
        check({tag, "_src_y"}, src_y, 0);
    endtask

    // One window: queue expectations, start, then wait (bounded) for done.
    // abort_at >= 0 pulls reset after that many accepted beats instead.
    task automatic run_window(input logic [31:0] s, input logic [31:0] c,
                              input bit rr, input int abort_at, input string tag);
        int base_done, base_acc, lat, n;
        bit got;
        rnd_ready = rr;
        for (int y = 0; y < WIN; y++)
            for (int x = 0; x < WIN; x++)
                sb_q.push_back(model(x, y, s, c));
        base_done = done_cnt;
        base_acc  = acc_total;
        @(negedge clk);
        sin_val = s;
        cos_val = c;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        sin_val = $urandom;
        cos_val = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            #2;
            lat++;
            got = out_valid;
        end
        check({tag, "_latency"}, lat, 4);
        n = 0;
        got = 1'b0;
        while (!got && n < 5000) begin
            @(negedge clk);
            #2;
            n++;
            if (abort_at >= 0 && (acc_total - base_acc) >= abort_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_midreset"});
                sb_q.delete();
                repeat (3) @(negedge clk);
                check({tag, "_no_done"}, done_cnt - base_done, 0);
                #2;
                rst_n = 1'b1;
                return;
            end
            got   = done;
            start = rr && busy && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        if (!rr) check({tag, "_cycles"}, n, 400);
        check({tag, "_accepted"}, acc_total - base_acc, WIN * WIN);
        check({tag, "_queue_empty"}, sb_q.size(), 0);
        if (got) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            #2;
            check({tag, "_start_on_done_ignored"}, busy, 0);
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - base_done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_window(32'h0000_0000, 32'h4000_0000, 1'b0, -1, "deg0");
        check("deg0_7_12_sx", $signed(got_sx[7][12]), 7);
        check("deg0_7_12_sy", $signed(got_sy[7][12]), 12);

        run_window(32'h4000_0000, 32'h0000_0000, 1'b0, -1, "deg90");
        check("deg90_0_0_sx", $signed(got_sx[0][0]), 0);
        check("deg90_0_0_sy", $signed(got_sy[0][0]), 19);
        check("deg90_19_0_sx", $signed(got_sx[19][0]), 0);
        check("deg90_19_0_sy", $signed(got_sy[19][0]), 0);
        check("deg90_19_19_sx", $signed(got_sx[19][19]), 19);
        check("deg90_19_19_sy", $signed(got_sy[19][19]), 0);

        run_window(32'h0000_0000, 32'hC000_0000, 1'b0, -1, "deg180");
        check("deg180_0_0_sx", $signed(got_sx[0][0]), 19);
        check("deg180_0_0_sy", $signed(got_sy[0][0]), 19);
        check("deg180_5_3_sx", $signed(got_sx[5][3]), 14);
        check("deg180_5_3_sy", $signed(got_sy[5][3]), 16);

        run_window(32'h2D41_3CCD, 32'h2D41_3CCD, 1'b0, -1, "deg45");
        check("deg45_0_0_sx", $signed(got_sx[0][0]), -4);
        check("deg45_0_0_oob", got_oob[0][0], 1);
        check("deg45_9_9_sx", $signed(got_sx[9][9]), 9);
        check("deg45_9_9_oob", got_oob[9][9], 0);

        run_window($urandom, $urandom, 1'b1, -1, "rand_ready_a");
        run_window($urandom, $urandom, 1'b1, -1, "rand_ready_b");

        run_window($urandom, $urandom, 1'b0, 150, "abort");
        repeat (2) @(negedge clk);
        run_window($urandom, $urandom, 1'b0, -1, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
